// File: rtl/arb_mem_2ph.sv
// Two-port two-phase request arbiter in front of a single-port word memory.
// Each granted access acknowledges DELAY clocks after its grant edge.
module arb_mem_2ph #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int DELAY      = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  r1,
   output logic                  a1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] din1,
   input  logic                  we1,
   input  logic                  r2,
   output logic                  a2,
   input  logic [ADDR_WIDTH-1:0] addr2,
   input  logic [DATA_WIDTH-1:0] din2,
   input  logic                  we2,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [1:0]            gnt
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state, state_n;
   logic [3:0]            cnt, cnt_n;
   logic                  own, own_n;
   logic                  last, last_n;
   logic                  lat_we, lat_we_n;
   logic [DATA_WIDTH-1:0] lat_din, lat_din_n;
   logic                  a1_n, a2_n;
   logic [DATA_WIDTH-1:0] dout_n;
   logic [DATA_WIDTH-1:0] rd_q;

   logic                  p1, p2, sel, take;
   logic [ADDR_WIDTH-1:0] g_addr;
   logic [DATA_WIDTH-1:0] g_din;
   logic                  g_we;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // own/last/sel: 0 = port 1, 1 = port 2
   always_comb begin
      p1     = r1 ^ a1;
      p2     = r2 ^ a2;
      sel    = !(p1 && (!p2 || last));
      take   = (state == IDLE) && (p1 || p2);
      g_addr = sel ? addr2 : addr1;
      g_din  = sel ? din2 : din1;
      g_we   = sel ? we2 : we1;
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      own_n     = own;
      last_n    = last;
      lat_we_n  = lat_we;
      lat_din_n = lat_din;
      a1_n      = a1;
      a2_n      = a2;
      dout_n    = dout;
      unique case (state)
         IDLE: begin
            if (take) begin
               state_n   = BUSY;
               cnt_n     = 4'(DELAY);
               own_n     = sel;
               lat_we_n  = g_we;
               lat_din_n = g_din;
            end
         end
         BUSY: begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_n = IDLE;
               last_n  = own;
               dout_n  = lat_we ? lat_din : rd_q;
               if (own) a2_n = ~a2;
               else     a1_n = ~a1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         own     <= 1'b0;
         last    <= 1'b1;
         lat_we  <= 1'b0;
         lat_din <= '0;
         a1      <= 1'b0;
         a2      <= 1'b0;
         dout    <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         own     <= own_n;
         last    <= last_n;
         lat_we  <= lat_we_n;
         lat_din <= lat_din_n;
         a1      <= a1_n;
         a2      <= a2_n;
         dout    <= dout_n;
      end
   end

   // Memory is written and read once, at the grant edge; no reset on contents
   always_ff @(posedge clk) begin
      if (take && rstn) begin
         if (g_we) mem[g_addr] <= g_din;
         rd_q <= mem[g_addr];
      end
   end

   assign gnt = (state == BUSY) ? (own ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_arb_mem_2ph.sv
// Bench for arb_mem_2ph: transaction-level model compared every cycle,
// plus directed sequences with literal expectations.
module tb_arb_mem_2ph;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int DL = 2;

   logic          clk = 0;
   logic          rstn = 0;
   logic          r1 = 0, r2 = 0;
   logic          we1 = 0, we2 = 0;
   logic [AW-1:0] addr1 = 0, addr2 = 0;
   logic [DW-1:0] din1 = 0, din2 = 0;
   logic          a1, a2;
   logic [DW-1:0] dout;
   logic [1:0]    gnt;

   int checks = 0;
   int errors = 0;

   arb_mem_2ph #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DELAY(DL)) dut (
      .clk(clk), .rstn(rstn),
      .r1(r1), .a1(a1), .addr1(addr1), .din1(din1), .we1(we1),
      .r2(r2), .a2(a2), .addr2(addr2), .din2(din2), .we2(we2),
      .dout(dout), .gnt(gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   // Transaction model: one access in flight, ack at grant cycle + DL
   int            cyc = 0;
   bit            started = 0;
   bit            busy = 0;
   bit            l2 = 1;
   bit            mo;
   int            ack_cyc;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mdin;
   bit            mwe;
   logic          ea1 = 0, ea2 = 0;
   logic [DW-1:0] ed = 0;
   bit            edk = 1;
   logic [DW-1:0] mm [int];

   always @(posedge clk) begin
      bit q1, q2;
      cyc++;
      if (!rstn) begin
         ea1 = 0; ea2 = 0; ed = 0; edk = 1;
         busy = 0; l2 = 1; started = 1;
      end else if (busy) begin
         if (cyc == ack_cyc) begin
            if (mo) ea2 = ~ea2;
            else    ea1 = ~ea1;
            if (mwe) begin
               ed = mdin; edk = 1;
            end else begin
               edk = mm.exists(int'(maddr));
               if (edk) ed = mm[int'(maddr)];
            end
            busy = 0;
            l2 = mo;
         end
      end else begin
         q1 = (r1 != ea1);
         q2 = (r2 != ea2);
         if (q1 || q2) begin
            mo = !(q1 && (!q2 || l2));
            maddr = mo ? addr2 : addr1;
            mdin  = mo ? din2 : din1;
            mwe   = mo ? we2 : we1;
            busy = 1;
            ack_cyc = cyc + DL;
            if (mwe) mm[int'(maddr)] = mdin;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("a1", 32'(a1), 32'(ea1));
         chk("a2", 32'(a2), 32'(ea2));
         chk("gnt", 32'(gnt),
             busy ? (mo ? 32'd2 : 32'd1) : 32'd0);
         if (edk) chk("dout", dout, ed);
      end
   end

   // Acknowledge log
   int            lp[$];
   logic [DW-1:0] ld[$];
   int            lc[$];
   logic          pa1 = 0, pa2 = 0;

   always @(negedge clk) begin
      if (rstn && started) begin
         if (a1 !== pa1) begin lp.push_back(1); ld.push_back(dout); lc.push_back(cyc); end
         if (a2 !== pa2) begin lp.push_back(2); ld.push_back(dout); lc.push_back(cyc); end
      end
      pa1 = a1;
      pa2 = a2;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_log();
      lp.delete(); ld.delete(); lc.delete();
   endtask

   task automatic wait_ack(input bit w1, input bit w2);
      int n = 0;
      while (((w1 && a1 !== r1) || (w2 && a2 !== r2)) && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL ack_timeout: a1=%b r1=%b a2=%b r2=%b", a1, r1, a2, r2);
      end
   endtask

   task automatic go1(input bit w, input logic [AW-1:0] ad,
                      input logic [DW-1:0] d);
      we1 = w; addr1 = ad; din1 = d; r1 = ~r1;
   endtask

   task automatic go2(input bit w, input logic [AW-1:0] ad,
                      input logic [DW-1:0] d);
      we2 = w; addr2 = ad; din2 = d; r2 = ~r2;
   endtask

   initial begin
      // Reset
      repeat (3) step();
      chk("rst_a1", 32'(a1), 32'd0);
      chk("rst_a2", 32'(a2), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_dout", dout, 32'd0);
      rstn = 1;
      repeat (3) step();
      chk("idle_gnt", 32'(gnt), 32'd0);

      // Single write with exact timing, then read back
      go1(1, 12'h010, 32'hDEADBEEF);
      step();
      chk("wr_gnt", 32'(gnt), 32'd1);
      chk("wr_a1_e0", 32'(a1), 32'd0);
      step();
      chk("wr_a1_e1", 32'(a1), 32'd0);
      step();
      chk("wr_a1_e2", 32'(a1), 32'd1);
      chk("wr_dout", dout, 32'hDEADBEEF);
      chk("wr_gnt_ack", 32'(gnt), 32'd0);
      go1(0, 12'h010, 32'h0);
      wait_ack(1, 0);
      chk("rd_dout", dout, 32'hDEADBEEF);

      // Preload, then simultaneous requests
      go1(1, 12'h020, 32'h11111111);
      wait_ack(1, 0);
      go2(1, 12'h030, 32'h22222222);
      wait_ack(0, 1);
      clr_log();
      go1(0, 12'h020, 32'h0);
      go2(0, 12'h030, 32'h0);
      wait_ack(1, 1);
      step();
      chk("tie_n", 32'(lp.size()), 32'd2);
      if (lp.size() == 2) begin
         chk("tie_p0", 32'(lp[0]), 32'd1);
         chk("tie_d0", ld[0], 32'h11111111);
         chk("tie_p1", 32'(lp[1]), 32'd2);
         chk("tie_d1", ld[1], 32'h22222222);
         chk("tie_gap", 32'(lc[1] - lc[0]), 32'(DL + 1));
      end
      // Port 1 served last, so port 2 wins the next tie
      go1(0, 12'h020, 32'h0);
      wait_ack(1, 0);
      clr_log();
      go1(0, 12'h020, 32'h0);
      go2(0, 12'h030, 32'h0);
      wait_ack(1, 1);
      step();
      chk("rr_n", 32'(lp.size()), 32'd2);
      if (lp.size() == 2) begin
         chk("rr_p0", 32'(lp[0]), 32'd2);
         chk("rr_d0", ld[0], 32'h22222222);
         chk("rr_p1", 32'(lp[1]), 32'd1);
      end

      // Request during BUSY
      clr_log();
      go1(0, 12'h020, 32'h0);
      step();
      go2(0, 12'h030, 32'h0);
      wait_ack(1, 1);
      step();
      chk("bsy_n", 32'(lp.size()), 32'd2);
      if (lp.size() == 2) begin
         chk("bsy_p0", 32'(lp[0]), 32'd1);
         chk("bsy_p1", 32'(lp[1]), 32'd2);
         chk("bsy_gap", 32'(lc[1] - lc[0]), 32'(DL + 1));
      end

      // Back-to-back reads on port 1
      for (int i = 0; i < 8; i++) begin
         go2(1, 12'h100 + 12'(i), 32'hA0000000 + 32'(i));
         wait_ack(0, 1);
      end
      clr_log();
      for (int i = 0; i < 8; i++) begin
         go1(0, 12'h100 + 12'(i), 32'h0);
         wait_ack(1, 0);
      end
      step();
      chk("b2b_n", 32'(lp.size()), 32'd8);
      if (lp.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("b2b_p", 32'(lp[i]), 32'd1);
            chk("b2b_d", ld[i], 32'hA0000000 + 32'(i));
            if (i > 0) chk("b2b_gap", 32'(lc[i] - lc[i-1]), 32'(DL + 1));
         end
      end

      // Reset one clock after a port 2 write grant
      go2(1, 12'h040, 32'hCAFEF00D);
      step();
      chk("mid_gnt", 32'(gnt), 32'd2);
      rstn = 0;
      r1 = 0;
      r2 = 0;
      step();
      step();
      chk("mid_a1", 32'(a1), 32'd0);
      chk("mid_a2", 32'(a2), 32'd0);
      chk("mid_gnt0", 32'(gnt), 32'd0);
      chk("mid_dout", dout, 32'd0);
      rstn = 1;
      step();
      clr_log();
      go1(0, 12'h040, 32'h0);
      wait_ack(1, 0);
      step();
      chk("mid_rd", dout, 32'hCAFEF00D);
      chk("mid_noa2", 32'(a2), 32'd0);

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arb_mem_2ph.md
# arb_mem_2ph

Clocked two-port memory front end for the asynchronous pipeline models. It arbitrates between two two-phase request/acknowledge channels, such as a PC-increment port and a branch port. The winner gets exclusive access to a single-port word memory. The acknowledge toggles after a fixed, buffer-like access delay. It replaces the separate arbiter, memory and delay-buffer cells with one synthesizable block.

## Interface
- ADDR_WIDTH, 12, word address width; memory depth is 2**ADDR_WIDTH words
- DATA_WIDTH, 32, data word width
- DELAY, 2, access latency in clocks from grant to acknowledge toggle; legal range 1..15
- clk  in  1  single clock, rising-edge
- rstn  in  1  reset, synchronous, active-low
- r1  in  1  port 1 request, two-phase: every toggle is one request
- a1  out  1  port 1 acknowledge, two-phase
- addr1  in  ADDR_WIDTH  port 1 word address
- din1  in  DATA_WIDTH  port 1 write data
- we1  in  1  port 1 write enable; 1 = write, 0 = read
- r2, a2, addr2, din2, we2  same as port 1, for port 2
- dout  out  DATA_WIDTH  access result for the most recently acknowledged port
- gnt  out  2  one-hot current owner: bit0 = port 1, bit1 = port 2; 00 = idle

## Operation
- Port i is pending when ri != ai. All inputs are synchronous to clk; there is no synchronizer.
- States:
  - IDLE: gnt = 00.
  - BUSY: owner latched; down-counter loaded with DELAY.
- IDLE, no pending port: stay in IDLE.
- IDLE, exactly one port pending: at the same edge:
  - enter BUSY and set gnt for that port;
  - latch addrN, dinN and weN;
  - if the write enable is set, write the memory.
- IDLE, both ports pending: round-robin. The port not granted last wins.
- last_grant resets to port 2, so port 1 wins the first tie.
- BUSY: the counter decrements each clock. At the edge where it reaches 0:
  - the owner's aN toggles;
  - dout loads the read data, or the written data for a write (write-through);
  - gnt returns to 00, last_grant is updated, and the state returns to IDLE.
- Requests that arrive while BUSY stay pending and are arbitrated at the first IDLE edge.
- A request that is not yet granted may be withdrawn by toggling ri back. It is then no longer pending and gets no acknowledge.
- A requester must not toggle ri again before ai equals ri. If it does while BUSY, the single acknowledge toggle leaves ri != ai and the port stays pending; the block takes no other corrective action.
- Memory contents are not reset. Reading an unwritten word returns an undefined value, and the bench must not check it.

## Timing
- Reset values: a1 = 0, a2 = 0, dout = 0, gnt = 00, state IDLE, counter 0, last_grant = port 2.
- Reset during BUSY aborts the access: no acknowledge and dout = 0. A write that was already granted stays committed in memory.
- Latency: request sampled pending at edge E0 (grant edge) -> aN toggles at edge E0 + DELAY.
- After an acknowledge, the next grant happens no earlier than the following edge. Minimum period per access is DELAY + 1 clocks.
- dout changes only on the acknowledge edge and is stable until the next acknowledge.
- gnt is high from the grant edge up to, not including, the acknowledge edge.
- At most one of a1/a2 toggles per edge.
- a1 and a2 never toggle without a preceding grant.

## Test plan
- Reset:
  - hold rstn = 0 for 3 clocks -> a1 = a2 = 0, gnt = 00, dout = 0.
  - release -> the block stays idle while r1 = r2 = 0.
- Single write then read, DELAY = 2:
  - toggle r1 with we1 = 1, addr1 = 0x010, din1 = 0xDEADBEEF -> gnt = 01 at the grant edge, a1 toggles 2 edges later, dout = 0xDEADBEEF.
  - toggle r1 again with we1 = 0, addr1 = 0x010 -> dout = 0xDEADBEEF on the second a1 toggle.
- Simultaneous requests:
  - toggle r1 and r2 on the same clock, reading preloaded 0x11111111 (port 1) and 0x22222222 (port 2) -> port 1 is served first, a1 toggles with dout = 0x11111111.
  - port 2 is granted on the next edge, and a2 toggles DELAY edges after its grant with dout = 0x22222222.
  - both ports re-request together -> port 2 wins this time (round-robin).
- Request during BUSY:
  - toggle r2 while port 1 is BUSY -> a2 does not toggle until a1 has toggled.
  - port 2's grant follows immediately at the next edge.
- Back-to-back throughput:
  - port 1 issues 8 reads, re-toggling r1 on the clock after each a1 toggle -> exactly 8 a1 toggles, each DELAY + 1 clocks apart, with correct dout sequence.
- Reset mid-access:
  - assert rstn = 0 one clock after a port 2 write grant (DELAY = 2) -> no a2 toggle, outputs return to reset values.
  - a subsequent read of that address returns the written data.
